// File: rtl/dot_accumulator_pkg.sv
// dot_accumulator_pkg: state encodings and sum-width helper for the bit-serial dot-product stage
package dot_accumulator_pkg;
  typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;
  function automatic int sum_w(input int len);
    return $clog2(len + 1);
  endfunction
endpackage

// File: rtl/multiplier.sv
// multiplier: 1-bit binary product
module multiplier (
  input  logic a,
  input  logic b,
  output logic prod
);
  assign prod = a & b;
endmodule

// File: rtl/dot_accumulator.sv
// dot_accumulator: counts a&b ones over LEN-pair frames and holds each frame sum until accepted
module dot_accumulator
  import dot_accumulator_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int SUM_W = sum_w(LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum,
  output logic [SUM_W-1:0] frame_cnt
);
  state_t state, state_nx;
  logic [SUM_W-1:0] acc, acc_nx, cnt_nx, sum_nx, acc_add;
  logic prod, last;
  multiplier u_mul (.a(a), .b(b), .prod(prod));
  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_HOLD);
  assign acc_add   = acc + SUM_W'(prod);
  assign last      = (frame_cnt == SUM_W'(LEN - 1));
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = frame_cnt;
    sum_nx   = sum;
    if (clear) begin
      state_nx = ST_ACCUM;
      acc_nx   = '0;
      cnt_nx   = '0;
    end else if (state == ST_ACCUM && in_valid) begin
      acc_nx   = last ? '0 : acc_add;
      cnt_nx   = last ? '0 : frame_cnt + 1'b1;
      sum_nx   = last ? acc_add : sum;
      state_nx = last ? ST_HOLD : ST_ACCUM;
    end else if (state == ST_HOLD && out_ready) begin
      state_nx = ST_ACCUM;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACCUM;
      acc       <= '0;
      frame_cnt <= '0;
      sum       <= '0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      frame_cnt <= cnt_nx;
      sum       <= sum_nx;
    end
  end
endmodule

// File: doc/dot_accumulator.md
# dot_accumulator

Bit-serial binary dot-product stage placed directly downstream of the 1-bit `multiplier`. It instantiates `multiplier`, feeds it one accepted (a, b) bit pair per cycle, and counts the product bits over a fixed frame of `LEN` pairs. It then presents the frame sum on a valid/ready output and holds it until the consumer accepts.

## Interface
- `LEN`, default 8: pairs per frame; must be ≥ 2.
- `SUM_W`, default `$clog2(LEN+1)`: sum width. It holds the values 0..LEN without overflow.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `clear`  in  1  synchronous frame abort. Discards the partial sum and any held result.
- `in_valid`  in  1  an (a, b) pair is offered.
- `in_ready`  out  1  the block can accept a pair.
- `a`  in  1  multiplicand bit.
- `b`  in  1  multiplier bit.
- `out_valid`  out  1  `sum` holds a completed frame result.
- `out_ready`  in  1  the consumer takes `sum`.
- `sum`  out  `SUM_W`  count of `a&b` ones in the frame.
- `frame_cnt`  out  `SUM_W`  number of pairs accepted in the current frame.

## Operation
- Reset values: state=`ACCUM`, `acc`=0, `frame_cnt`=0, `sum`=0, `out_valid`=0, `in_ready`=1.
- There are two states, `ACCUM` and `HOLD`.
- In `ACCUM`:
  - `in_ready`=1 and `out_valid`=0.
  - A transfer occurs when `in_valid`=1. On a transfer, `acc` += `prod` and `frame_cnt` += 1.
  - A transfer while `frame_cnt`==LEN-1 ends the frame:
    - `sum` <= `acc + prod` and `out_valid` <= 1.
    - `acc` <= 0 and `frame_cnt` <= 0.
    - The state moves to `HOLD`.
- In `HOLD`:
  - `in_ready`=0 and `out_valid`=1.
  - `sum` stays stable and does not depend on `a`, `b` or `in_valid`.
  - A handshake (`out_ready`=1) clears `out_valid` and returns the state to `ACCUM`.
  - Exactly one bubble cycle follows before the next pair can be accepted.
- `clear`=1, in either state:
  - Next state is `ACCUM`, with `acc`=0, `frame_cnt`=0 and `out_valid`=0.
  - `sum` keeps its last value.
  - `clear` overrides any simultaneous input or output transfer; that transfer is dropped.
- `in_ready` is a function of state only. There is no combinational path from `in_valid` or `out_ready` to `in_ready`.
- When `in_valid`=0, `acc` and `frame_cnt` hold.
- Width rules:
  - `acc` is `SUM_W` bits and never exceeds LEN-1 before the final add.
  - The final add fits in `SUM_W` bits.

## Timing
- Latency: the result is valid in the cycle after the LEN-th accepted pair.
- Best-case throughput: one frame per LEN+1 cycles (LEN transfers plus the handshake cycle).
- The `prod` path is combinational within the accept cycle (`a`, `b` → `multiplier` → adder → `acc` register).
- An `rst_n` assertion mid-frame or in `HOLD` returns all outputs to their reset values immediately. Deassertion is synchronised externally.
- `out_ready` asserted in `ACCUM` has no effect.

## Structure
- Shared package/header holds:
  - state encodings `ST_ACCUM`=1'b0 and `ST_HOLD`=1'b1;
  - the `SUM_W` computation helper.
- One sub-module: the existing `multiplier` (ports `a`, `b`, `prod`), instantiated as `u_mul`.
- Everything else (FSM, counter, accumulator, output register) stays flat in `dot_accumulator`.

## Test plan
- LEN=4, reset. Stream a=1,1,1,1 and b=1,0,1,0 with `in_valid` held and `out_ready`=1. Required: `out_valid` one cycle after the 4th pair with `sum`=2, then `in_ready`=1 on the next cycle.
- LEN=4, all pairs a=b=1, `out_ready`=0 for 5 cycles. Required: `sum`=4 (max, no wrap), held stable, and `in_ready`=0 throughout the stall.
- LEN=4, `in_valid` toggling 1,0,0,1,1,0,1 with a=b=1. Required: only the 4 valid pairs counted, giving `sum`=4, with `frame_cnt` stepping 1,1,1,2,3,3,0.
- LEN=4, two pairs a=b=1, then `clear`=1 together with `in_valid`=1. Required: `frame_cnt`=0 and `acc`=0. A following frame with a=b=1 on one pair only gives `sum`=1.
- `rst_n` pulsed low while in `HOLD` with `sum`=3. Required: asynchronously `out_valid`=0, `sum`=0 and `in_ready`=1 before the next clock edge.
- LEN=8, frame of a=b=0. Required: `sum`=0 with `out_valid`=1, and `clear` asserted in `HOLD` drops `out_valid` the next cycle.
